// File: rtl/fixed_act_lut_loader_if.sv
// fixed_act_lut_loader_if: table-write, lookup-in and result-out streams of the LUT activation stage.
interface fixed_act_lut_loader_if #(
  parameter int N  = 1,
  parameter int IW = 8,
  parameter int OW = 8
);
  logic [OW-1:0]        lut_in_data;
  logic                 lut_in_valid;
  logic                 lut_in_ready;
  logic                 reload;
  logic                 lut_loaded;
  logic [N-1:0][IW-1:0] data_in_0;
  logic                 data_in_0_valid;
  logic                 data_in_0_ready;
  logic [N-1:0][OW-1:0] data_out_0;
  logic                 data_out_0_valid;
  logic                 data_out_0_ready;
  modport slave (
    input  lut_in_data, lut_in_valid, reload, data_in_0, data_in_0_valid, data_out_0_ready,
    output lut_in_ready, lut_loaded, data_in_0_ready, data_out_0, data_out_0_valid
  );
  modport master (
    output lut_in_data, lut_in_valid, reload, data_in_0, data_in_0_valid, data_out_0_ready,
    input  lut_in_ready, lut_loaded, data_in_0_ready, data_out_0, data_out_0_valid
  );
endinterface

// File: rtl/fixed_act_lut_loader.sv
// fixed_act_lut_loader: streamed-table LUT activation; FIXED_ACT_LUT_CHECKSUM_EN adds a lut_checksum output.
module fixed_act_lut_loader #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int LUT_DEPTH                   = 2 ** DATA_IN_0_PRECISION_0
) (
  input logic clk,
  input logic rst,
  fixed_act_lut_loader_if.slave io
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
  ,
  output logic [15:0] lut_checksum
`endif
);
  localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IW = DATA_IN_0_PRECISION_0;
  localparam int OW = DATA_OUT_0_PRECISION_0;

  if (LUT_DEPTH != 2 ** IW) $error("LUT_DEPTH must equal 2**DATA_IN_0_PRECISION_0");
  if (DATA_IN_0_PRECISION_1 > IW || DATA_OUT_0_PRECISION_1 > OW) $error("fractional bits exceed word width");

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        wr_ptr_q, wr_ptr_d;
  logic                 loaded_q, loaded_d;
  logic                 valid_q, valid_d;
  logic [N-1:0][OW-1:0] out_q, out_d;
  logic [N-1:0][OW-1:0] rd;
  logic [OW-1:0]        lut_q [LUT_DEPTH];
  logic                 lut_wr, in_hs;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
  logic [15:0]          csum_q, csum_d;
`endif

  assign io.lut_in_ready     = state_q == LOAD;
  assign io.data_in_0_ready  = state_q == RUN && (!valid_q || io.data_out_0_ready);
  assign io.lut_loaded       = loaded_q;
  assign io.data_out_0_valid = valid_q;
  assign io.data_out_0       = out_q;
  assign lut_wr              = state_q == LOAD && io.lut_in_valid;
  assign in_hs               = io.data_in_0_valid && io.data_in_0_ready;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
  assign lut_checksum        = csum_q;
`endif

  // Inverting the operand MSB maps signed input -2^(P-1)..2^(P-1)-1 onto table index 0..LUT_DEPTH-1
  always_comb begin
    rd = '0;
    for (int i = 0; i < N; i++)
      rd[i] = lut_q[{~io.data_in_0[i][IW-1], io.data_in_0[i][IW-2:0]}];
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    loaded_d = loaded_q;
    valid_d  = in_hs ? 1'b1 : (io.data_out_0_ready ? 1'b0 : valid_q);
    out_d    = in_hs ? rd : out_q;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
    csum_d   = lut_wr ? csum_q + 16'(io.lut_in_data) : csum_q;
`endif
    case (state_q)
      LOAD: if (lut_wr) begin
        wr_ptr_d = wr_ptr_q + IW'(1);
        state_d  = &wr_ptr_q ? RUN : LOAD;
        loaded_d = &wr_ptr_q;
      end
      RUN: state_d = io.reload ? DRAIN : RUN;
      DRAIN: if (!valid_q || io.data_out_0_ready) begin
        state_d  = LOAD;
        loaded_d = 1'b0;
        wr_ptr_d = '0;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
        csum_d   = '0;
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      loaded_q <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk)
    if (lut_wr) lut_q[wr_ptr_q] <= io.lut_in_data;
endmodule

// File: tb/tb_fixed_act_lut_loader.sv
// tb_fixed_act_lut_loader: directed scoreboard bench for the streamed-table LUT activation stage, 4 lanes.
module tb_fixed_act_lut_loader;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [31:0] q [$];
  int          hq [$];
  logic        pend = 1'b0;
  logic [31:0] held;
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
  logic [15:0] lut_checksum;
`endif

  fixed_act_lut_loader_if #(.N(N), .IW(8), .OW(8)) io ();

  fixed_act_lut_loader #(.DATA_IN_0_PARALLELISM_DIM_0(N)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
    ,
    .lut_checksum(lut_checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else begin
      if (io.data_out_0_valid) begin
        if (pend) chk("hold_stable", io.data_out_0, held);
        else if (q.size() == 0 || hq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h want none", io.data_out_0);
        end else begin
          chk("result", io.data_out_0, q.pop_front());
          chk("latency", cyc - hq.pop_front(), 1);
        end
        held = io.data_out_0;
      end
      pend = io.data_out_0_valid && !io.data_out_0_ready;
      if (io.data_in_0_valid && io.data_in_0_ready) hq.push_back(cyc);
    end
  end

  function automatic logic [7:0] ent(input int mode, input int k);
    case (mode)
      0: return 8'(k);
      1: return 8'(255 - k);
      2: return 8'(k) ^ 8'hA5;
      3: return 8'h01;
      4: return 8'h02;
      default: return 8'h33;
    endcase
  endfunction

  task automatic load(input int mode, input int n);
    bit ok;
    int t;
    io.lut_in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      io.lut_in_data = ent(mode, k);
      t = 0;
      do begin
        @(negedge clk);
        ok = io.lut_in_ready;
        if (k == 255 && t == 0) chk("loaded_before_last", io.lut_loaded, 0);
        if (k == 0 && t == 0) chk("in_ready_in_load", io.data_in_0_ready, 0);
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 20);
      if (!ok) chk("lut_write_timeout", 0, 1);
    end
    io.lut_in_valid = 1'b0;
    if (n == 256) chk("loaded_after_last", io.lut_loaded, 1);
  endtask

  task automatic send(input logic [31:0] din, input logic [31:0] exp, input bit rl);
    bit ok;
    int t = 0;
    io.data_in_0 = din;
    io.data_in_0_valid = 1'b1;
    io.reload = rl;
    q.push_back(exp);
    do begin
      @(negedge clk);
      ok = io.data_in_0_ready;
      @(posedge clk);
      #1;
      io.reload = 1'b0;
      t++;
    end while (!ok && t < 50);
    if (!ok) chk("input_timeout", 0, 1);
    io.data_in_0_valid = 1'b0;
  endtask

  task automatic wait_load;
    int t = 0;
    while (!io.lut_in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("reached_load", io.lut_in_ready, 1);
    chk("unloaded_in_load", io.lut_loaded, 0);
  endtask

  task automatic do_reload;
    io.reload = 1'b1;
    @(posedge clk);
    #1;
    io.reload = 1'b0;
    wait_load();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    io.lut_in_data = '0;
    io.lut_in_valid = 1'b0;
    io.reload = 1'b0;
    io.data_in_0 = '0;
    io.data_in_0_valid = 1'b0;
    io.data_out_0_ready = 1'b1;
    #13;
    chk("rst_loaded", io.lut_loaded, 0);
    chk("rst_valid", io.data_out_0_valid, 0);
    chk("rst_data", io.data_out_0, 0);
    chk("rst_lut_ready", io.lut_in_ready, 1);
    chk("rst_in_ready", io.data_in_0_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(0, 256);
    send(32'h00000000, 32'h80808080, 1'b0);
    send(32'h7F7F7F7F, 32'hFFFFFFFF, 1'b0);
    send(32'h80808080, 32'h00000000, 1'b0);
    send(32'h80FF0100, 32'h007F8180, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    io.data_out_0_ready = 1'b0;
    fork
      begin
        send(32'h01F02010, 32'h8170A090, 1'b0);
        send(32'h7E7E7E7E, 32'hFEFEFEFE, 1'b0);
        send(32'h81818181, 32'h01010101, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", io.data_in_0_ready, 0);
        chk("stall_valid", io.data_out_0_valid, 1);
        @(posedge clk);
        #1;
        io.data_out_0_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    send(32'h80FF0100, 32'h007F8180, 1'b1);
    chk("drain_in_ready", io.data_in_0_ready, 0);
    io.data_out_0_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_waits", io.lut_in_ready, 0);
    io.data_out_0_ready = 1'b1;
    wait_load();
    load(1, 256);
    send(32'h80FF0100, 32'hFF807E7F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reload();
    load(5, 100);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_loaded", io.lut_loaded, 0);
    chk("midrst_valid", io.data_out_0_valid, 0);
    chk("midrst_data", io.data_out_0, 0);
    chk("midrst_lut_ready", io.lut_in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(2, 256);
    send(32'h80FF0100, 32'hA5DA2425, 1'b0);
    send(32'h00000000, 32'h25252525, 1'b0);
`ifdef FIXED_ACT_LUT_CHECKSUM_EN
    repeat (3) @(posedge clk);
    #1;
    do_reload();
    chk("csum_cleared", lut_checksum, 0);
    load(3, 256);
    chk("csum_ones", lut_checksum, 16'h0100);
    do_reload();
    load(4, 256);
    chk("csum_twos", lut_checksum, 16'h0200);
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fixed_act_lut_loader.md
Name: fixed_act_lut_loader

Overview:
Runtime-programmable, LUT-based fixed-point activation stage (SiLU, GELU, etc.). Replaces the compile-time table file with a streamed table-write port.
- The block first accepts all LUT entries on a write stream.
- It then serves valid/ready activation lookups through a 1-cycle registered output.
- It sits in the activations library between a config/DMA producer (table writer) and the datapath, drop-in compatible with the existing data_in_0/data_out_0 stream interface.

Parameters:
DATA_IN_0_PRECISION_0, 8, input word width; LUT address width.
DATA_IN_0_PRECISION_1, 4, input fractional bits (documentation only).
DATA_IN_0_PARALLELISM_DIM_0, 1, lanes dim 0.
DATA_IN_0_PARALLELISM_DIM_1, 1, lanes dim 1.
DATA_OUT_0_PRECISION_0, 8, output word width; LUT entry width.
DATA_OUT_0_PRECISION_1, 4, output fractional bits (documentation only).
LUT_DEPTH, 2**DATA_IN_0_PRECISION_0, derived table depth; must not be overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
lut_in_data  input  DATA_OUT_0_PRECISION_0  table entry being written.
lut_in_valid  input  1  table entry valid.
lut_in_ready  output  1  block accepts table entry.
reload  input  1  single-cycle request to reprogram the table.
lut_loaded  output  1  table complete; lookups enabled.
data_in_0  input  [N][DATA_IN_0_PRECISION_0]  lookup operands, N = DIM_0*DIM_1.
data_in_0_valid  input  1  operands valid.
data_in_0_ready  output  1  block accepts operands.
data_out_0  output  [N][DATA_OUT_0_PRECISION_0]  activation results.
data_out_0_valid  output  1  results valid.
data_out_0_ready  input  1  downstream accepts results.

Behaviour:
- Reset (rst low, async) forces:
  - state=LOAD, wr_ptr=0, lut_loaded=0, data_out_0_valid=0, data_out_0=0, lut_in_ready=1, data_in_0_ready=0.
  - Table contents are not reset.
- Table addressing: entry written at index k is the result for signed input k-2^(P-1), P=DATA_IN_0_PRECISION_0. Lookup address = data_in_0[i] with MSB inverted (offset binary). Example: input 0x00 reads index 128; input 0x80 reads index 0.
- State LOAD:
  - lut_in_ready=1, data_in_0_ready=0.
  - Each lut_in_valid&&lut_in_ready writes table[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr=LUT_DEPTH-1 moves to RUN next cycle, with lut_loaded=1 and wr_ptr wrapping to 0.
  - reload is ignored in LOAD.
- State RUN:
  - lut_in_ready=0; writes are not accepted.
  - data_in_0_ready = !data_out_0_valid || data_out_0_ready.
  - On input handshake, all N lanes look up the same table in parallel (multi-read-port or replicated storage) and register into data_out_0. data_out_0_valid=1 next cycle. Latency is exactly 1 cycle, throughput 1 per cycle.
  - Output holds stable while data_out_0_valid && !data_out_0_ready.
  - Output valid clears when consumed and no new input arrives.
- reload in RUN: next state is DRAIN, and data_in_0_ready=0 from the following cycle. An input handshake in the same cycle as reload is still accepted and completes.
- State DRAIN:
  - Waits until the output register is empty (data_out_0_valid=0, or consumed this cycle).
  - Then moves to LOAD with lut_loaded=0 and wr_ptr=0.
  - No results computed with the old table are lost.
- Reset mid-LOAD restarts at wr_ptr=0. A partial table is never used because lut_loaded=0.

Optional Feature:
FIXED_ACT_LUT_CHECKSUM_EN:
- When defined, adds output port lut_checksum [15:0], the modulo-2^16 sum of all entries (zero-extended) written since the last entry to LOAD.
  - Cleared on reset and on the DRAIN->LOAD transition.
  - Stable while lut_loaded=1.
- When undefined, the port and accumulator are absent; all other behaviour is identical.

Test Plan:
1. After reset, load lut[k]=k for k=0..255 with continuous valid -> lut_loaded rises the cycle after the 256th handshake. Then send 0x00, 0x7F, 0x80 -> outputs 0x80, 0xFF, 0x00, each 1 cycle after its input handshake.
2. Hold data_out_0_ready=0 for 5 cycles with 3 inputs offered -> first result held stable, data_in_0_ready=0, no drops. Releasing ready yields all 3 results in order.
3. Assert reload in the same cycle as an input handshake -> that result still emerges, then lut_loaded=0 and lut_in_ready=1. Reload with lut[k]=255-k, then input 0x00 -> 0x7F.
4. Pull rst low after 100 table writes -> lut_loaded=0, outputs invalid. Full 256-entry load then completes normally and lookups match the new table.
5. With FIXED_ACT_LUT_CHECKSUM_EN, load all entries = 0x01 -> lut_checksum = 0x0100. After reload with all 0x02 -> 0x0200.
6. PARALLELISM_DIM_0=4 with lanes {0x00, 0x01, 0xFF, 0x80} and identity table -> outputs {0x80, 0x81, 0x7F, 0x00} in one beat.
